// File: rtl/regr_line_walker_if.sv
// ============================================================================
// Module      : regr_line_walker_if
// Description : Coefficient input, point stream and status for the walker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regr_line_walker_if;
    logic signed [17:0] a_in;
    logic signed [24:0] b_in;
    logic               coeff_valid_in;
    logic               ready_in;
    logic        [10:0] x_out;
    logic        [9:0]  y_out;
    logic               on_screen_out;
    logic               valid_out;
    logic               busy_out;
    logic               done_out;

    // Regression engine / overlay side: supplies the line, consumes points.
    modport master (
        output a_in, b_in, coeff_valid_in, ready_in,
        input  x_out, y_out, on_screen_out, valid_out, busy_out, done_out
    );

    // Walker side.
    modport slave (
        input  a_in, b_in, coeff_valid_in, ready_in,
        output x_out, y_out, on_screen_out, valid_out, busy_out, done_out
    );
endinterface

`default_nettype wire

// File: rtl/regr_line_walker.sv
// ============================================================================
// Module      : regr_line_walker
// Description : Latches a fitted line y = a + b*x and streams clamped (x, y)
//               points for x = X_START..X_END through a 2-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regr_line_walker #(
    parameter int X_START   = 0,
    parameter int X_END     = 1023,
    parameter int Y_MAX     = 767,
    parameter int FRAC_BITS = 8
) (
    input  wire logic          clk_in,
    input  wire logic          rst_in,
    regr_line_walker_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic        [10:0] c_X_START = 11'(X_START);
    localparam logic        [10:0] c_X_END   = 11'(X_END);
    localparam logic        [9:0]  c_Y_MAX   = 10'(Y_MAX);
    localparam logic signed [37:0] c_Y_LIMIT = 38'(Y_MAX);

    state_t r_state;
    state_t w_state_next;

    logic signed [17:0] r_a;
    logic signed [24:0] r_b;
    logic        [10:0] r_x_cnt;

    logic               r_s1_valid;
    logic signed [36:0] r_s1_prod;
    logic        [10:0] r_s1_x;

    logic               r_valid;
    logic        [10:0] r_x;
    logic        [9:0]  r_y;
    logic               r_on;
    logic               r_done;

    logic               w_latch;
    logic               w_push;
    logic               w_done_set;
    logic               w_out_stall;
    logic               w_s1_free;
    logic               w_last_hs;

    logic signed [36:0] w_b_ext;
    logic signed [36:0] w_x_ext;
    logic signed [36:0] w_prod;
    logic signed [36:0] w_shifted;
    logic signed [37:0] w_a_ext;
    logic signed [37:0] w_sh_ext;
    logic signed [37:0] w_y_full;
    logic        [9:0]  w_y_clamped;
    logic               w_on;

    // Output register holds while presented and not taken; stage 1 may still
    // fill a bubble behind it.
    assign w_out_stall = r_valid & ~bus.ready_in;
    assign w_s1_free   = ~r_s1_valid | ~w_out_stall;
    assign w_last_hs   = r_valid & bus.ready_in & (r_x == c_X_END);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_push       = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.coeff_valid_in) begin
                    w_latch      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_s1_free) begin
                    w_push = 1'b1;
                    if (r_x_cnt == c_X_END) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_last_hs) begin
                    w_done_set   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Coefficients and x counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_a     <= '0;
            r_b     <= '0;
            r_x_cnt <= '0;
        end else if (w_latch) begin
            r_a     <= bus.a_in;
            r_b     <= bus.b_in;
            r_x_cnt <= c_X_START;
        end else if (w_push && (r_x_cnt != c_X_END)) begin
            r_x_cnt <= r_x_cnt + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: slope times x (x treated as non-negative)
    // ------------------------------------------------------------------
    assign w_b_ext = {{12{r_b[24]}}, r_b};
    assign w_x_ext = {26'd0, r_x_cnt};
    assign w_prod  = w_b_ext * w_x_ext;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_x     <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= w_push;
            if (w_push) begin
                r_s1_prod <= w_prod;
                r_s1_x    <= r_x_cnt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: intercept add and screen clamp. The arithmetic shift floors
    // toward minus infinity, so small negative slopes step down at x=1.
    // ------------------------------------------------------------------
    assign w_shifted = r_s1_prod >>> FRAC_BITS;
    assign w_a_ext   = {{20{r_a[17]}}, r_a};
    assign w_sh_ext  = {w_shifted[36], w_shifted};
    assign w_y_full  = w_a_ext + w_sh_ext;

    always_comb begin
        w_y_clamped = w_y_full[9:0];
        w_on        = 1'b1;
        if (w_y_full[37]) begin
            w_y_clamped = 10'd0;
            w_on        = 1'b0;
        end else if (w_y_full > c_Y_LIMIT) begin
            w_y_clamped = c_Y_MAX;
            w_on        = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_valid <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_on    <= 1'b0;
        end else if (!w_out_stall) begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_x  <= r_s1_x;
                r_y  <= w_y_clamped;
                r_on <= w_on;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

    assign bus.x_out         = r_x;
    assign bus.y_out         = r_y;
    assign bus.on_screen_out = r_on;
    assign bus.valid_out     = r_valid;
    assign bus.busy_out      = (r_state != ST_IDLE);
    assign bus.done_out      = r_done;

endmodule

`default_nettype wire
